// File: rtl/kronos_mem_arbiter.sv
// Shares one memory port between the fetch and load/store ports of kronos_core.
// Registered grant FSM; acks and read data are passed straight back to the owner.
module kronos_mem_arbiter #(
  parameter int unsigned DATA_PRIORITY = 1,
  parameter int unsigned MAX_WAIT      = 8
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_ack,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd_data,
  output logic [1:0]  owner
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGntI = 2'b01,
    StGntD = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_i_q, wait_i_d;
  logic [CntW-1:0] wait_d_q, wait_d_d;

  logic ack_i, ack_d;
  logic req_i_eff, req_d_eff;

  assign ack_i = mem_ack & (state_q == StGntI);
  assign ack_d = mem_ack & (state_q == StGntD);

  // The port being acked this cycle is done, so it must not win the next grant.
  assign req_i_eff = instr_req & ~ack_i;
  assign req_d_eff = data_req & ~ack_d;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q  <= StIdle;
      wait_i_q <= '0;
      wait_d_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_i_q <= wait_i_d;
      wait_d_q <= wait_d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == StIdle) || mem_ack) begin
      if (req_i_eff && req_d_eff) begin
        if (DATA_PRIORITY != 0) begin
          state_d = (wait_i_q == MaxCnt) ? StGntI : StGntD;
        end else begin
          state_d = (wait_d_q == MaxCnt) ? StGntD : StGntI;
        end
      end else if (req_i_eff) begin
        state_d = StGntI;
      end else if (req_d_eff) begin
        state_d = StGntD;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    wait_i_d = wait_i_q;
    wait_d_d = wait_d_q;
    if (!instr_req || (state_q == StGntI)) begin
      wait_i_d = '0;
    end else if (wait_i_q != MaxCnt) begin
      wait_i_d = wait_i_q + 1'b1;
    end
    if (!data_req || (state_q == StGntD)) begin
      wait_d_d = '0;
    end else if (wait_d_q != MaxCnt) begin
      wait_d_d = wait_d_q + 1'b1;
    end
  end

  // Shared-port fields come from the registered grant only.
  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_mask    = '0;
    mem_wr_en   = 1'b0;
    mem_req     = 1'b0;
    unique case (state_q)
      StGntI: begin
        mem_addr = instr_addr;
        mem_mask = 4'hF;
        mem_req  = instr_req;
      end
      StGntD: begin
        mem_addr    = data_addr;
        mem_wr_data = data_wr_data;
        mem_mask    = data_mask;
        mem_wr_en   = data_wr_en;
        mem_req     = data_req;
      end
      default: ;
    endcase
  end

  assign instr_ack    = ack_i;
  assign data_ack     = ack_d;
  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;
  assign owner        = state_q;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Scoreboard bench for kronos_mem_arbiter: directed scenarios, then random traffic
// checked against a per-cycle grant model and per-port request queues.
module tb_kronos_mem_arbiter;

  localparam int MaxWait = 3;
  localparam int DataPri = 1;

  logic        clk;
  logic        rstz;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack;
  logic [31:0] data_rd_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rd_data;
  logic [1:0]  owner;

  kronos_mem_arbiter #(
    .DATA_PRIORITY(DataPri),
    .MAX_WAIT     (MaxWait)
  ) dut (
    .clk         (clk),
    .rstz        (rstz),
    .instr_addr  (instr_addr),
    .instr_req   (instr_req),
    .instr_ack   (instr_ack),
    .instr_data  (instr_data),
    .data_addr   (data_addr),
    .data_wr_data(data_wr_data),
    .data_mask   (data_mask),
    .data_wr_en  (data_wr_en),
    .data_req    (data_req),
    .data_ack    (data_ack),
    .data_rd_data(data_rd_data),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_mask    (mem_mask),
    .mem_wr_en   (mem_wr_en),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rd_data (mem_rd_data),
    .owner       (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wr_en;
  } req_t;

  req_t iq[$];
  req_t dq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who should own the port, and how long each port has waited.
  int m_owner = 0;
  int m_wi = 0;
  int m_wd = 0;
  int n_wi, n_wd;
  bit ri, rd, ai, ad;
  logic exp_req;

  always @(negedge clk) begin
    if (!rstz) begin
      m_owner = 0;
      m_wi = 0;
      m_wd = 0;
      iq.delete();
      dq.delete();
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_acks", 32'({instr_ack, data_ack}), 32'd0);
    end else begin
      ai = mem_ack && (m_owner == 1);
      ad = mem_ack && (m_owner == 2);
      exp_req = (m_owner == 1) ? instr_req : (m_owner == 2) ? data_req : 1'b0;
      chk("owner", 32'(owner), 32'(m_owner));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("instr_ack", 32'(instr_ack), 32'(ai));
      chk("data_ack", 32'(data_ack), 32'(ad));
      if (m_owner == 0) begin
        chk("idle_fields", 32'({mem_mask, mem_wr_en}), 32'd0);
        chk("idle_addr", mem_addr, 32'd0);
        chk("idle_wdata", mem_wr_data, 32'd0);
      end else if (m_owner == 1 && iq.size() > 0) begin
        chk("fetch_addr", mem_addr, iq[0].addr);
        chk("fetch_mask_we", 32'({mem_mask, mem_wr_en}), 32'({4'hF, 1'b0}));
      end else if (m_owner == 2 && dq.size() > 0) begin
        chk("data_addr", mem_addr, dq[0].addr);
        chk("data_wdata", mem_wr_data, dq[0].wdata);
        chk("data_mask_we", 32'({mem_mask, mem_wr_en}), 32'({dq[0].mask, dq[0].wr_en}));
      end
      if (instr_ack) begin
        chk("instr_data", instr_data, mem_rd_data);
        if (iq.size() > 0) void'(iq.pop_front());
      end
      if (data_ack) begin
        if (dq.size() > 0 && !dq[0].wr_en) chk("load_data", data_rd_data, mem_rd_data);
        if (dq.size() > 0) void'(dq.pop_front());
      end
      ri = instr_req && !ai;
      rd = data_req && !ad;
      n_wi = (!instr_req || m_owner == 1) ? 0 : ((m_wi < MaxWait) ? m_wi + 1 : MaxWait);
      n_wd = (!data_req || m_owner == 2) ? 0 : ((m_wd < MaxWait) ? m_wd + 1 : MaxWait);
      if (m_owner == 0 || mem_ack) begin
        if (ri && rd) begin
          if (DataPri != 0) m_owner = (m_wi == MaxWait) ? 1 : 2;
          else m_owner = (m_wd == MaxWait) ? 2 : 1;
        end else begin
          m_owner = ri ? 1 : (rd ? 2 : 0);
        end
      end
      m_wi = n_wi;
      m_wd = n_wd;
    end
  end

  task automatic issue_instr(input logic [31:0] a);
    req_t r;
    instr_addr = a;
    instr_req = 1'b1;
    r.addr = a;
    r.wdata = '0;
    r.mask = 4'hF;
    r.wr_en = 1'b0;
    iq.push_back(r);
  endtask

  task automatic issue_data(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m,
                            input logic we);
    req_t r;
    data_addr = a;
    data_wr_data = w;
    data_mask = m;
    data_wr_en = we;
    data_req = 1'b1;
    r.addr = a;
    r.wdata = w;
    r.mask = m;
    r.wr_en = we;
    dq.push_back(r);
  endtask

  bit ia, da;
  int mem_cnt = 0;

  // One cycle of autonomous requesters plus a memory with random ack latency.
  task automatic step(input int pi, input int pd, input int maxd, input int stray);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (ia) instr_req = 1'b0;
    if (da) data_req = 1'b0;
    if (!instr_req && $urandom_range(0, 99) < pi) issue_instr($urandom & 32'hFFFF_FFFC);
    if (!data_req && $urandom_range(0, 99) < pd)
      issue_data($urandom, $urandom, 4'($urandom), 1'($urandom));
    #1;
    if (mem_req) begin
      if (mem_cnt == 0) begin
        mem_ack = 1'b1;
        mem_rd_data = $urandom;
        mem_cnt = $urandom_range(0, maxd);
      end else begin
        mem_cnt--;
      end
    end else if ($urandom_range(0, 99) < stray) begin
      mem_ack = 1'b1;
      mem_rd_data = $urandom;
    end
    #1;
    ia = instr_ack;
    da = data_ack;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  int waited;

  initial begin
    rstz = 1'b0;
    instr_addr = '0;
    instr_req = 1'b1;
    data_addr = '0;
    data_wr_data = '0;
    data_mask = '0;
    data_wr_en = 1'b0;
    data_req = 1'b1;
    mem_ack = 1'b0;
    mem_rd_data = '0;
    ia = 0;
    da = 0;
    repeat (3) edge1();
    chk("t1_mem_req", 32'(mem_req), 32'd0);
    chk("t1_owner", 32'(owner), 32'd0);
    instr_req = 1'b0;
    data_req = 1'b0;
    edge1();
    rstz = 1'b1;
    edge1();

    // Single fetch, memory acks two cycles after the request.
    issue_instr(32'h100);
    #1 chk("t2_no_req_same_cycle", 32'(mem_req), 32'd0);
    edge1();
    chk("t2_mem_req", 32'(mem_req), 32'd1);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mask", 32'(mem_mask), 32'hF);
    edge1();
    mem_ack = 1'b1;
    mem_rd_data = 32'hCAFE_0001;
    #1 chk("t2_instr_ack", 32'(instr_ack), 32'd1);
    chk("t2_instr_data", instr_data, 32'hCAFE_0001);
    edge1();
    mem_ack = 1'b0;
    instr_req = 1'b0;
    edge1();

    // Collision: data first, then instr with no idle gap.
    issue_instr(32'h204);
    issue_data(32'h300, 32'h0, 4'hF, 1'b0);
    edge1();
    chk("t3_owner_d", 32'(owner), 32'd2);
    edge1();
    mem_ack = 1'b1;
    mem_rd_data = 32'h1111_2222;
    edge1();
    mem_ack = 1'b0;
    data_req = 1'b0;
    #1 chk("t3_owner_i", 32'(owner), 32'd1);
    chk("t3_no_gap", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    mem_rd_data = 32'h3333_4444;
    edge1();
    mem_ack = 1'b0;
    instr_req = 1'b0;
    edge1();

    // Store forwarding.
    issue_data(32'h400, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    edge1();
    chk("t5_wdata", mem_wr_data, 32'hDEAD_BEEF);
    chk("t5_mask_we", 32'({mem_mask, mem_wr_en}), 32'({4'b0011, 1'b1}));
    edge1();
    mem_ack = 1'b1;
    #1 chk("t5_data_ack", 32'(data_ack), 32'd1);
    chk("t5_instr_ack", 32'(instr_ack), 32'd0);
    edge1();
    mem_ack = 1'b0;
    data_req = 1'b0;
    edge1();

    // Fetch must not starve behind continuous back-to-back data traffic.
    issue_instr(32'h500);
    issue_data(32'h600, 32'h0, 4'hF, 1'b0);
    ia = 0;
    da = 0;
    mem_cnt = 0;
    waited = 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 100, 0, 0);
      if (owner == 2'b01) break;
      waited++;
    end
    chk("t4_starve_bound", 32'(waited <= MaxWait + 1), 32'd1);
    repeat (6) step(0, 0, 0, 0);

    // Async reset while data owns the port; the late ack must be dropped.
    issue_data(32'h700, 32'h0, 4'hF, 1'b0);
    edge1();
    chk("t6_owner_d", 32'(owner), 32'd2);
    #1 rstz = 1'b0;
    data_req = 1'b0;
    #1 chk("t6_owner_rst", 32'(owner), 32'd0);
    chk("t6_req_rst", 32'(mem_req), 32'd0);
    edge1();
    rstz = 1'b1;
    mem_ack = 1'b1;
    #1 chk("t6_late_ack", 32'({instr_ack, data_ack}), 32'd0);
    edge1();
    mem_ack = 1'b0;
    ia = 0;
    da = 0;
    mem_cnt = 0;

    for (int i = 0; i < 2000; i++) step(30, 30, 3, 10);
    for (int i = 0; i < 30; i++) step(0, 0, 3, 0);
    chk("drain_iq", 32'(iq.size()), 32'd0);
    chk("drain_dq", 32'(dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
